dino_anim_fsm: RTL

- Registered successor to the dino sprite selector.
- Tracks the dino's animation state (idle, run, duck, jump, dead) from game state and physics flags.
- Cycles per-state animation frames on a divided animation tick, with configurable frame counts.
- Drives the sprite ROM select and emits a one-cycle landing pulse for sound/dust logic. Sits between the physics/jump block and the dino sprite renderer.

---
 rtl/dino_anim_fsm_pkg.sv | 23 ++
 rtl/dino_anim_fsm_if.sv | 28 ++
 rtl/dino_anim_fsm_anim_frame_ctr.sv | 41 ++++
 rtl/dino_anim_fsm.sv | 117 +++++++++++
 4 files changed

// File: rtl/dino_anim_fsm_pkg.sv
// Shared definitions for the dino animation controller: state encoding,
// game_state codes and the sprite ROM select packing.
package dino_pkg;

  // Animation state encoding, also the upper bits of sprite_sel.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DUCK = 3'd2,
    JUMP = 3'd3,
    DEAD = 3'd4
  } anim_state_t;

  localparam int STATE_W = 3;

  localparam logic [1:0] GS_MENU = 2'b00;
  localparam logic [1:0] GS_OVER = 2'b01;
  localparam logic [1:0] GS_PLAY = 2'b10;

  // sprite_sel packing: {anim_state[STATE_W-1:0], frame_idx[FRAME_W-1:0]},
  // so each state owns a contiguous block of 2^FRAME_W ROM entries.

endpackage

// File: rtl/dino_anim_fsm_if.sv
// Signal bundle between physics/game logic and the dino animation block.
// master drives game inputs and receives sprite outputs; slave is the FSM.
interface dino_anim_fsm_if #(
  parameter int FRAME_W = 2
);
  import dino_pkg::*;

  logic                       anim_tick;
  logic [1:0]                 game_state;
  logic                       airborne;
  logic                       on_ground;
  logic                       duck_req;
  logic [STATE_W-1:0]         anim_state;
  logic [FRAME_W-1:0]         frame_idx;
  logic [STATE_W+FRAME_W-1:0] sprite_sel;
  logic                       land_pulse;

  modport master (
    output anim_tick, game_state, airborne, on_ground, duck_req,
    input  anim_state, frame_idx, sprite_sel, land_pulse
  );

  modport slave (
    input  anim_tick, game_state, airborne, on_ground, duck_req,
    output anim_state, frame_idx, sprite_sel, land_pulse
  );

endinterface

// File: rtl/dino_anim_fsm_anim_frame_ctr.sv
// Tick divider plus modulo frame counter. clr wins over counting; a frame
// count of 1 pins the frame index at 0.
module anim_frame_ctr #(
  parameter int ANIM_DIV = 1,
  parameter int FRAME_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               tick,
  input  logic [FRAME_W:0]   frames,
  output logic [FRAME_W-1:0] frame
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [DIV_W-1:0] div;

  // divider and frame index advance together on the wrapping tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      frame <= '0;
    end else if (clr) begin
      div   <= '0;
      frame <= '0;
    end else if (en && tick) begin
      if (div == DIV_W'(ANIM_DIV - 1)) begin
        div <= '0;
        if ({1'b0, frame} == frames - (FRAME_W+1)'(1))
          frame <= '0;
        else
          frame <= frame + FRAME_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/dino_anim_fsm.sv
// Dino animation state tracker. Registered outputs, one cycle latency.
// Optional idle blink enabled by defining DINO_BLINK_EN.
//
// state | meaning
// IDLE  | menu screen, static pose (blinks when DINO_BLINK_EN)
// RUN   | on ground, run cycle frames
// DUCK  | on ground with duck held, duck cycle frames
// JUMP  | airborne; landing emits land_pulse
// DEAD  | game over, latched until menu
module dino_anim_fsm
  import dino_pkg::*;
#(
  parameter int RUN_FRAMES   = 2,
  parameter int DUCK_FRAMES  = 2,
  parameter int ANIM_DIV     = 1,
  parameter int FRAME_W      = 2,
  parameter int BLINK_PERIOD = 64
) (
  input logic            clk,
  input logic            rst_n,
  dino_anim_fsm_if.slave bus
);

  anim_state_t        state, nxt;
  logic               land_nxt, land_q;
  logic               ctr_clr, ctr_en;
  logic [FRAME_W:0]   frames;
  logic [FRAME_W-1:0] ctr_frame;
  logic               blink_on;

  // state and landing pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      land_q <= 1'b0;
    end else begin
      state  <= nxt;
      land_q <= land_nxt;
    end
  end

  // next-state decode: menu > game over > reserved hold > play rules
  always_comb begin
    nxt      = state;
    land_nxt = 1'b0;
    unique case (bus.game_state)
      GS_MENU: nxt = IDLE;
      GS_OVER: nxt = DEAD;
      GS_PLAY: begin
        case (state)
          IDLE: nxt = bus.airborne ? JUMP : RUN;
          RUN, DUCK: begin
            if (bus.airborne)                       nxt = JUMP;
            else if (bus.on_ground && bus.duck_req) nxt = DUCK;
            else if (bus.on_ground)                 nxt = RUN;
          end
          JUMP: begin
            if (!bus.airborne && bus.on_ground) begin
              nxt      = bus.duck_req ? DUCK : RUN;
              land_nxt = 1'b1;
            end
          end
          DEAD:    nxt = DEAD;
          default: nxt = IDLE;
        endcase
      end
      default: nxt = state;
    endcase
  end

  // frame counter only runs while staying in RUN/DUCK; a transition on a
  // tick edge clears instead of advancing
  always_comb begin
    ctr_en  = (state == RUN) || (state == DUCK);
    ctr_clr = (nxt != state) || !ctr_en;
    frames  = (state == DUCK) ? (FRAME_W+1)'(DUCK_FRAMES) : (FRAME_W+1)'(RUN_FRAMES);
  end

  anim_frame_ctr #(
    .ANIM_DIV (ANIM_DIV),
    .FRAME_W  (FRAME_W)
  ) u_frame_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .tick   (bus.anim_tick),
    .frames (frames),
    .frame  (ctr_frame)
  );

`ifdef DINO_BLINK_EN
  localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [BLINK_W-1:0] blink_cnt;

  // idle blink counter; the last count is the one-tick blink frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blink_cnt <= '0;
    else if (state != IDLE || nxt != IDLE)
      blink_cnt <= '0;
    else if (bus.anim_tick)
      blink_cnt <= (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) ? '0 : blink_cnt + BLINK_W'(1);
  end

  assign blink_on = (state == IDLE) && (blink_cnt == BLINK_W'(BLINK_PERIOD - 1));
`else
  assign blink_on = 1'b0;
`endif

  assign bus.anim_state = state;
  assign bus.frame_idx  = blink_on ? FRAME_W'(1) : ctr_frame;
  assign bus.sprite_sel = {state, bus.frame_idx};
  assign bus.land_pulse = land_q;

endmodule
